// File: rtl/axi_bridge_pkg.sv
// Shared FSM type, AXI encodings and sizing helper for the N-port cache-to-AXI bridge.
package axi_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_AR,
      ST_R,
      ST_AW,
      ST_W,
      ST_B,
      ST_DONE
   } state_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   localparam logic [2:0] AXI_SIZE_1B = 3'd0;
   localparam logic [2:0] AXI_SIZE_2B = 3'd1;
   localparam logic [2:0] AXI_SIZE_4B = 3'd2;
   localparam logic [2:0] AXI_SIZE_8B = 3'd3;

   // Width of an index into n items, never less than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/axi_nport_bridge_rr_arbiter.sv
// Requester arbiter: round-robin with AXI_NPORT_BRIDGE_RR_EN defined, fixed lowest-index priority otherwise.
module rr_arbiter
   import axi_bridge_pkg::*;
#(
   parameter int NPORT = 2,
   parameter int IDX_W = idx_w(NPORT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NPORT-1:0] req,
   input  logic             en,
   output logic [NPORT-1:0] grant,
   output logic [IDX_W-1:0] idx
);

`ifdef AXI_NPORT_BRIDGE_RR_EN
   logic [IDX_W-1:0] ptr;
   logic             found;

   // Ports above the last winner first, then wrap round to the low ones.
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < NPORT; k++) begin
         if (!found && req[k] && (IDX_W'(k) > ptr)) begin
            found    = 1'b1;
            grant[k] = 1'b1;
            idx      = IDX_W'(k);
         end
      end
      for (int k = 0; k < NPORT; k++) begin
         if (!found && req[k] && (IDX_W'(k) <= ptr)) begin
            found    = 1'b1;
            grant[k] = 1'b1;
            idx      = IDX_W'(k);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ptr <= IDX_W'(NPORT - 1);
      else if (en && found)
         ptr <= idx;
   end
`else
   logic unused_ok;
   assign unused_ok = clk ^ rst ^ en;

   always_comb begin
      grant = '0;
      idx   = '0;
      for (int k = NPORT - 1; k >= 0; k--) begin
         if (req[k]) begin
            grant    = '0;
            grant[k] = 1'b1;
            idx      = IDX_W'(k);
         end
      end
   end
`endif

endmodule

// File: rtl/axi_nport_bridge.sv
// N-port SRAM-like requester to single AXI3 master bridge, one transaction in flight.
// Grant policy selected by AXI_NPORT_BRIDGE_RR_EN (round-robin) or fixed priority when undefined.
module axi_nport_bridge
   import axi_bridge_pkg::*;
#(
   parameter int NPORT     = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int ID_W      = 4,
   parameter int MAX_BURST = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NPORT-1:0]            req,
   input  logic [NPORT-1:0]            wr,
   input  logic [2*NPORT-1:0]          size,
   input  logic [8*NPORT-1:0]          len,
   input  logic [ADDR_W*NPORT-1:0]     addr,
   input  logic [DATA_W*NPORT-1:0]     wdata,
   input  logic [(DATA_W/8)*NPORT-1:0] wstrb,
   output logic [NPORT-1:0]            wnext,
   output logic [DATA_W-1:0]           rdata_o,
   output logic [NPORT-1:0]            rbeat,
   output logic [NPORT-1:0]            dok,
   output logic                        stall,
   output logic [ID_W-1:0]             arid,
   output logic [ADDR_W-1:0]           araddr,
   output logic [3:0]                  arlen,
   output logic [2:0]                  arsize,
   output logic [1:0]                  arburst,
   output logic [1:0]                  arlock,
   output logic [3:0]                  arcache,
   output logic [2:0]                  arprot,
   output logic                        arvalid,
   input  logic                        arready,
   input  logic [ID_W-1:0]             rid,
   input  logic [DATA_W-1:0]           rdata,
   input  logic [1:0]                  rresp,
   input  logic                        rlast,
   input  logic                        rvalid,
   output logic                        rready,
   output logic [ID_W-1:0]             awid,
   output logic [ADDR_W-1:0]           awaddr,
   output logic [3:0]                  awlen,
   output logic [2:0]                  awsize,
   output logic [1:0]                  awburst,
   output logic [1:0]                  awlock,
   output logic [3:0]                  awcache,
   output logic [2:0]                  awprot,
   output logic                        awvalid,
   input  logic                        awready,
   output logic [ID_W-1:0]             wid,
   output logic [DATA_W-1:0]           axi_wdata,
   output logic [DATA_W/8-1:0]         axi_wstrb,
   output logic                        wlast,
   output logic                        wvalid,
   input  logic                        wready,
   input  logic [ID_W-1:0]             bid,
   input  logic [1:0]                  bresp,
   input  logic                        bvalid,
   output logic                        bready
);

   localparam int IDX_W  = idx_w(NPORT);
   localparam int CNT_W  = idx_w(MAX_BURST);
   localparam int STRB_W = DATA_W / 8;

   state_t              state;
   logic [NPORT-1:0]    arb_grant;
   logic [IDX_W-1:0]    arb_idx;
   logic [IDX_W-1:0]    g_idx;
   logic [NPORT-1:0]    g_mask;
   logic [7:0]          len_q;
   logic [CNT_W-1:0]    cnt;
   logic                sel_wr;
   logic [1:0]          sel_size;
   logic [7:0]          sel_len;
   logic [ADDR_W-1:0]   sel_addr;
   logic                unused_ok;

   rr_arbiter #(.NPORT(NPORT), .IDX_W(IDX_W)) u_arb (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .en    (state == ST_IDLE),
      .grant (arb_grant),
      .idx   (arb_idx)
   );

   // Request fields of the arbiter winner, and write payload of the latched owner.
   always_comb begin
      sel_wr    = 1'b0;
      sel_size  = '0;
      sel_len   = '0;
      sel_addr  = '0;
      axi_wdata = '0;
      axi_wstrb = '0;
      g_mask    = '0;
      for (int i = 0; i < NPORT; i++) begin
         if (arb_idx == IDX_W'(i)) begin
            sel_wr   = wr[i];
            sel_size = size[2*i +: 2];
            sel_len  = len[8*i +: 8];
            sel_addr = addr[ADDR_W*i +: ADDR_W];
         end
         if (g_idx == IDX_W'(i)) begin
            axi_wdata = wdata[DATA_W*i +: DATA_W];
            axi_wstrb = wstrb[STRB_W*i +: STRB_W];
            g_mask[i] = 1'b1;
         end
      end
   end

   assign rbeat   = (rready && rvalid) ? g_mask : '0;
   assign wnext   = (wvalid && wready) ? g_mask : '0;
   assign dok     = ((rready && rvalid && rlast) || (bready && bvalid)) ? g_mask : '0;
   assign stall   = |(req & ~dok);
   assign rdata_o = rdata;

   assign arburst = AXI_BURST_INCR;
   assign awburst = AXI_BURST_INCR;
   assign arlock  = '0;
   assign awlock  = '0;
   assign arcache = '0;
   assign awcache = '0;
   assign arprot  = '0;
   assign awprot  = '0;

   assign unused_ok = ^{rid, rresp, bid, bresp, len_q[7:4]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         arvalid <= 1'b0;
         rready  <= 1'b0;
         awvalid <= 1'b0;
         wvalid  <= 1'b0;
         wlast   <= 1'b0;
         bready  <= 1'b0;
         arid    <= '0;
         awid    <= '0;
         wid     <= '0;
         araddr  <= '0;
         awaddr  <= '0;
         arlen   <= '0;
         awlen   <= '0;
         arsize  <= '0;
         awsize  <= '0;
         g_idx   <= '0;
         len_q   <= '0;
         cnt     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (arb_grant != '0) begin
                  g_idx <= arb_idx;
                  len_q <= sel_len;
                  cnt   <= '0;
                  if (sel_wr) begin
                     awvalid <= 1'b1;
                     awid    <= ID_W'(arb_idx);
                     wid     <= ID_W'(arb_idx);
                     awaddr  <= sel_addr;
                     awlen   <= sel_len[3:0];
                     awsize  <= {1'b0, sel_size};
                     state   <= ST_AW;
                  end else begin
                     arvalid <= 1'b1;
                     arid    <= ID_W'(arb_idx);
                     araddr  <= sel_addr;
                     arlen   <= sel_len[3:0];
                     arsize  <= {1'b0, sel_size};
                     state   <= ST_AR;
                  end
               end
            end
            ST_AR: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state   <= ST_R;
               end
            end
            ST_R: begin
               if (rvalid && rlast) begin
                  rready <= 1'b0;
                  state  <= ST_DONE;
               end
            end
            ST_AW: begin
               if (awready) begin
                  awvalid <= 1'b0;
                  wvalid  <= 1'b1;
                  wlast   <= (len_q[CNT_W-1:0] == '0);
                  cnt     <= '0;
                  state   <= ST_W;
               end
            end
            ST_W: begin
               if (wready) begin
                  cnt <= cnt + CNT_W'(1);
                  if (wlast) begin
                     wvalid <= 1'b0;
                     wlast  <= 1'b0;
                     bready <= 1'b1;
                     state  <= ST_B;
                  end else begin
                     wlast <= ((cnt + CNT_W'(1)) == len_q[CNT_W-1:0]);
                  end
               end
            end
            ST_B: begin
               if (bvalid) begin
                  bready <= 1'b0;
                  state  <= ST_DONE;
               end
            end
            // One dead cycle so a registered requester can drop req before re-arbitration.
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_nport_bridge.sv
// Bench for axi_nport_bridge; acts as requesters and AXI slave, expected grants follow AXI_NPORT_BRIDGE_RR_EN.
module tb_axi_nport_bridge;

   localparam int NPORT  = 2;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int ID_W   = 4;
   localparam int SW     = DATA_W / 8;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [NPORT-1:0]        req, wr;
   logic [2*NPORT-1:0]      size;
   logic [8*NPORT-1:0]      len;
   logic [ADDR_W*NPORT-1:0] addr;
   logic [DATA_W*NPORT-1:0] wdata;
   logic [SW*NPORT-1:0]     wstrb;
   logic [NPORT-1:0]        wnext, rbeat, dok;
   logic [DATA_W-1:0]       rdata_o;
   logic                    stall;
   logic [ID_W-1:0]         arid, awid, wid, rid, bid;
   logic [ADDR_W-1:0]       araddr, awaddr;
   logic [3:0]              arlen, awlen, arcache, awcache;
   logic [2:0]              arsize, awsize, arprot, awprot;
   logic [1:0]              arburst, awburst, arlock, awlock, rresp, bresp;
   logic                    arvalid, arready, rlast, rvalid, rready;
   logic                    awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic [DATA_W-1:0]       rdata, axi_wdata;
   logic [SW-1:0]           axi_wstrb;

   int total = 0;
   int bad   = 0;
   int last_g;

   always #5 clk = ~clk;

   axi_nport_bridge #(.NPORT(NPORT), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MAX_BURST(8)) dut (
      .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .len(len), .addr(addr),
      .wdata(wdata), .wstrb(wstrb), .wnext(wnext), .rdata_o(rdata_o), .rbeat(rbeat),
      .dok(dok), .stall(stall),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .wlast(wlast), .wvalid(wvalid),
      .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_port(input int p, input logic w, input int l, input logic [31:0] a);
      wr[p]           = w;
      len[p*8 +: 8]   = l[7:0];
      addr[p*32 +: 32] = a;
      size[p*2 +: 2]  = 2'd2;
   endtask

   // Reference grant policy written from the rules, independent of the arbiter's structure.
   task automatic model_grant(input logic [NPORT-1:0] r, output int g);
      g = -1;
`ifdef AXI_NPORT_BRIDGE_RR_EN
      for (int i = 1; i <= NPORT; i++) begin
         int c;
         c = (last_g + i) % NPORT;
         if (g < 0 && r[c]) g = c;
      end
`else
      for (int i = NPORT - 1; i >= 0; i--)
         if (r[i]) g = i;
`endif
      if (g >= 0) last_g = g;
   endtask

   // Called in an IDLE cycle with req already set; returns at the start of the DONE cycle.
   task automatic read_txn(input int g, input int l, input logic [31:0] a, input int ar_wait,
                           input int gap_max, input bit rnd);
      logic [NPORT-1:0] oh;
      logic [31:0]      d;
      oh = '0;
      oh[g] = 1'b1;
      #1 check("stall_req", stall, 1);
      cyc();
      check("arvalid_c1", arvalid, 1);
      check("arid", arid, g);
      check("araddr", araddr, a);
      check("arlen", arlen, l);
      check("arsize", arsize, 2);
      check("arburst", arburst, 1);
      check("awvalid_rd", awvalid, 0);
      for (int k = 0; k < ar_wait; k++) begin
         #1 check("ar_hold_v", arvalid, 1);
         check("ar_hold_a", araddr, a);
         check("ar_stall", stall, 1);
         cyc();
      end
      arready = 1'b1;
      #1;
      cyc();
      arready = 1'b0;
      for (int b = 0; b <= l; b++) begin
         int gap;
         gap = $urandom_range(gap_max, 0);
         for (int k = 0; k < gap; k++) begin
            rvalid = 1'b0;
            #1 check("rbeat_idle", rbeat, 0);
            check("rready", rready, 1);
            cyc();
         end
         d      = rnd ? $urandom : 32'(b);
         rvalid = 1'b1;
         rdata  = d;
         rlast  = (b == l);
         rid    = ID_W'(g);
         #1 check("rbeat", rbeat, oh);
         check("rdata_o", rdata_o, d);
         check("dok_rd", dok, (b == l) ? oh : {NPORT{1'b0}});
         cyc();
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
      #1 check("rready_done", rready, 0);
      check("dok_done", dok, 0);
      check("arvalid_done", arvalid, 0);
   endtask

   task automatic write_txn(input int g, input int l, input logic [31:0] a, input int aw_wait,
                            input int stall_beat, input int stall_n, input int bdelay,
                            input logic [31:0] base, input bit rnd);
      logic [NPORT-1:0] oh;
      logic [31:0]      d[16];
      logic [3:0]       s[16];
      oh = '0;
      oh[g] = 1'b1;
      for (int b = 0; b <= l; b++) begin
         d[b] = rnd ? $urandom : base + 32'(b);
         s[b] = rnd ? 4'($urandom) : 4'hF;
      end
      wdata[g*32 +: 32] = d[0];
      wstrb[g*4 +: 4]   = s[0];
      #1 check("stall_wreq", stall, 1);
      cyc();
      check("awvalid_c1", awvalid, 1);
      check("awid", awid, g);
      check("awaddr", awaddr, a);
      check("awlen", awlen, l);
      check("awsize", awsize, 2);
      check("awburst", awburst, 1);
      check("arvalid_wr", arvalid, 0);
      for (int k = 0; k < aw_wait; k++) begin
         #1 check("aw_hold_v", awvalid, 1);
         check("aw_hold_a", awaddr, a);
         cyc();
      end
      awready = 1'b1;
      #1;
      cyc();
      awready = 1'b0;
      for (int b = 0; b <= l; b++) begin
         wdata[g*32 +: 32] = d[b];
         wstrb[g*4 +: 4]   = s[b];
         if (b == stall_beat) begin
            for (int k = 0; k < stall_n; k++) begin
               wready = 1'b0;
               #1 check("wvalid_stall", wvalid, 1);
               check("wnext_stall", wnext, 0);
               check("wdata_stall", axi_wdata, d[b]);
               check("wlast_stall", wlast, (b == l));
               cyc();
            end
         end
         wready = 1'b1;
         #1 check("wvalid", wvalid, 1);
         check("wid", wid, g);
         check("wdata", axi_wdata, d[b]);
         check("wstrb", axi_wstrb, s[b]);
         check("wlast", wlast, (b == l));
         check("wnext", wnext, oh);
         check("dok_w", dok, 0);
         cyc();
      end
      wready = 1'b0;
      #1 check("wvalid_b", wvalid, 0);
      check("bready", bready, 1);
      for (int k = 0; k < bdelay; k++) begin
         #1 check("dok_bwait", dok, 0);
         cyc();
      end
      bvalid = 1'b1;
      bid    = ID_W'(g);
      #1 check("dok_b", dok, oh);
      cyc();
      bvalid = 1'b0;
      #1 check("bready_done", bready, 0);
      check("dok_bdone", dok, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1, "watchdog");
   end

   initial begin
      int          g;
      logic [NPORT-1:0] r;
      int          pl[NPORT];
      logic [31:0] pa[NPORT];
      logic        pw[NPORT];

      rst = 1'b1;
      req = '0; wr = '0; size = '0; len = '0; addr = '0; wdata = '0; wstrb = '0;
      arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
      awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
      last_g = NPORT - 1;
      repeat (3) cyc();

      // Reset state
      check("rst_arvalid", arvalid, 0);
      check("rst_awvalid", awvalid, 0);
      check("rst_wvalid", wvalid, 0);
      check("rst_rready", rready, 0);
      check("rst_bready", bready, 0);
      check("rst_ids", {arid, awid, wid}, 0);
      check("rst_araddr", araddr, 0);
      check("rst_awaddr", awaddr, 0);
      check("rst_pulses", {rbeat, wnext, dok}, 0);
      check("rst_stall", stall, 0);
      check("rst_tie", {arlock, arcache, arprot, awlock, awcache, awprot}, 0);
      rst = 1'b0;
      cyc();

      // Port 1 eight-beat read, data 0..7; req held through DONE must not re-grant
      req = 2'b10;
      set_port(1, 1'b0, 7, 32'h1FC0_0000);
      model_grant(req, g);
      read_txn(g, 7, 32'h1FC0_0000, 0, 0, 1'b0);
      cyc();
      req = '0;
      #1 check("no_dup_ar", arvalid, 0);
      cyc();
      check("no_dup_ar2", arvalid, 0);
      check("no_dup_aw", awvalid, 0);

      // Port 0 four-beat write with wready stalled two cycles on beat 2
      req = 2'b01;
      set_port(0, 1'b1, 3, 32'h0000_1000);
      model_grant(req, g);
      write_txn(g, 3, 32'h0000_1000, 0, 2, 2, 1, 32'hA0, 1'b0);
      req = '0;
      cyc();

      // arready held low ten cycles
      req = 2'b01;
      set_port(0, 1'b0, 0, 32'h0000_3040);
      model_grant(req, g);
      read_txn(g, 0, 32'h0000_3040, 10, 0, 1'b1);
      req = '0;
      cyc();

      // Both ports requesting repeatedly
      for (int p = 0; p < NPORT; p++) begin
         pl[p] = $urandom_range(3, 0);
         pa[p] = $urandom & 32'hFFFF_FFC0;
         set_port(p, 1'b0, pl[p], pa[p]);
      end
      for (int it = 0; it < 4; it++) begin
         req = 2'b11;
         model_grant(req, g);
         read_txn(g, pl[g], pa[g], 0, 1, 1'b1);
         req = '0;
         cyc();
      end

      // Random mix of reads and writes from random requester sets
      for (int it = 0; it < 12; it++) begin
         r = NPORT'($urandom_range(3, 1));
         for (int p = 0; p < NPORT; p++) begin
            pw[p] = 1'($urandom_range(1, 0));
            pl[p] = $urandom_range(7, 0);
            pa[p] = $urandom & 32'hFFFF_FFC0;
            set_port(p, pw[p], pl[p], pa[p]);
         end
         req = r;
         model_grant(r, g);
         if (pw[g])
            write_txn(g, pl[g], pa[g], $urandom_range(2, 0), $urandom_range(pl[g], 0),
                      $urandom_range(2, 0), $urandom_range(2, 0), 32'h0, 1'b1);
         else
            read_txn(g, pl[g], pa[g], $urandom_range(2, 0), 2, 1'b1);
         req = '0;
         cyc();
      end

      // Reset during W beat 2
      req = 2'b01;
      set_port(0, 1'b1, 3, 32'h0000_2000);
      model_grant(req, g);
      wdata[31:0] = 32'hB0;
      wstrb[3:0]  = 4'hF;
      cyc();
      check("rstw_aw", awvalid, 1);
      awready = 1'b1;
      #1;
      cyc();
      awready = 1'b0;
      wready  = 1'b1;
      #1 check("rstw_beat0", wnext, 2'b01);
      cyc();
      #1 check("rstw_beat1", wnext, 2'b01);
      cyc();
      wready = 1'b0;
      #1 check("rstw_pre", wvalid, 1);
      rst = 1'b1;
      last_g = NPORT - 1;
      #1 check("rstw_valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
      check("rstw_dok", dok, 0);
      cyc();
      check("rstw_valids2", {arvalid, awvalid, wvalid, rready, bready}, 0);
      check("rstw_dok2", dok, 0);
      req = '0;
      cyc();
      rst = 1'b0;
      cyc();
      check("rstw_idle", {arvalid, awvalid, wvalid}, 0);
      check("rstw_dok3", dok, 0);

      // First grant after reset with both requesting
      req = 2'b11;
      set_port(0, 1'b0, 1, 32'h0000_4000);
      set_port(1, 1'b0, 1, 32'h0000_5000);
      model_grant(req, g);
      read_txn(g, 1, (g == 0) ? 32'h0000_4000 : 32'h0000_5000, 0, 1, 1'b1);
      req = '0;
      cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axi_nport_bridge.md
# axi_nport_bridge

Parametrised successor to the two-port cache-to-AXI bridge: arbitrates NPORT SRAM-like cache-side requesters (I-cache, D-cache, uncached/write-buffer ports) onto a single AXI3 master port, with INCR bursts for cache-line refill and write-back. Sits between the cache layer and the SoC AXI crossbar, one transaction in flight at a time, and drives the pipeline-wide stall while any requester is waiting.

## Interface
- NPORT, 2: number of requester ports, 2..8
- ADDR_W, 32: address width
- DATA_W, 32: AXI and requester data width
- ID_W, 4: AXI ID width; ID = granted port index
- MAX_BURST, 8: maximum beats per transaction, power of two

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req  in  NPORT  per-port request; held until that port's dok
- wr  in  NPORT  1 = write
- size  in  2*NPORT  beat size, AXI arsize/awsize encoding (low 2 bits)
- len  in  8*NPORT  beats minus 1; must be < MAX_BURST
- addr  in  ADDR_W*NPORT  start address
- wdata  in  DATA_W*NPORT  current write beat
- wstrb  in  (DATA_W/8)*NPORT  current write byte strobes
- wnext  out  NPORT  pulse: current write beat accepted, present next
- rdata_o  out  DATA_W  read beat, shared by all ports
- rbeat  out  NPORT  pulse: rdata_o valid for that port
- dok  out  NPORT  pulse: transaction complete
- stall  out  1  = |(req & ~dok)
- AXI3 master AR, R, AW, W, B channels with standard names (arid..arvalid/arready, rid..rready, awid..awready, wid..wready, bid..bready); lock/cache/prot tied 0; burst = INCR (2'b01)

## Operation
- FSM states: IDLE, AR, R, AW, W, B, DONE.
- IDLE: if any req, arbiter picks grant g; latch wr, size, len, addr of g; next state AR (wr=0) or AW (wr=1). Inputs of g after latch are ignored except wdata/wstrb.
- AR: arvalid=1, araddr/arlen/arsize/arid from latch; on arready -> R.
- R: rready=1; each beat rvalid&rready: rbeat[g]=1, rdata_o=rdata; beat with rlast: dok[g]=1 -> DONE. rid and rresp not checked.
- AW: awvalid=1; on awready -> W, beat counter cleared.
- W: wvalid=1, wdata/wstrb muxed combinationally from port g, wid=g, wlast when counter==len; on wready: wnext[g]=1, counter+1; last beat -> B.
- B: bready=1; on bvalid: dok[g]=1 -> DONE. bresp ignored.
- DONE: one cycle, all req ignored (lets requester deassert registered req); -> IDLE.
- Beat counter width log2(MAX_BURST); len >= MAX_BURST is illegal, behaviour undefined.
- Requests from non-granted ports wait; stall stays high for them.

## Timing
- Reset: all AXI valid/ready low, arid/awid/wid 0, addresses 0, rbeat/wnext/dok 0, state IDLE, round-robin pointer = NPORT-1 (port 0 first).
- Minimum single-beat read: req sampled cycle 0, arvalid cycle 1, R cycle 2, dok same cycle as rvalid&rlast, IDLE cycle 4 after DONE.
- rbeat, wnext, dok, stall combinational from AXI handshakes in current state; all other AXI outputs registered or from latched state.
- valid signals never drop before their ready (AXI rule).
- Simultaneous req from several ports: one grant per IDLE cycle.
- Reset mid-transaction: immediate return to IDLE, outstanding AXI transfer abandoned (system-wide reset only).

## Configuration
- AXI_NPORT_BRIDGE_RR_EN defined: round-robin grant, search starts at last granted+1, wraps at NPORT-1 -> 0.
- Not defined: fixed priority, lowest index wins; pointer register removed.

## Structure
- Package axi_bridge_pkg: state enum, AXI_BURST_INCR, AXI size constants, port-index width function.
- Sub-module rr_arbiter (NPORT requests in, one-hot grant + index out, pointer update on grant enable); honours the macro.

## Test plan
- Port 1 read, len=7, addr 0x1FC0_0000, slave returns 0..7 -> arlen=7, arid=1, eight rbeat[1] pulses with data 0..7, dok[1] on eighth, arvalid cycle 1.
- Port 0 write len=3, wdata 0xA0..0xA3, wready stalls 2 cycles on beat 2 -> wnext[0] x4, wlast only on 0xA3, dok[0] with bvalid.
- req=2'b11 repeatedly (RR on) -> grants 0,1,0,1; macro off -> always 0 while req[0] held.
- arready held low 10 cycles -> arvalid/araddr stable, stall=1 throughout.
- rst asserted during W beat 2 -> all valids 0 next edge, state IDLE, dok never pulses.
- req held high one cycle after dok -> DONE prevents duplicate grant; no second arvalid.
